axi4_wr_arbiter: RTL and testbench

AXI4_WR_ARBITER -- requirements
Module: axi4_wr_arbiter

---
 rtl/axi4_wr_arbiter_pkg.sv | 20 ++
 rtl/axi4_wr_arbiter_rr_pick.sv | 25 ++
 rtl/axi4_wr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi4_wr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_parameters
//   Shared widths and the FSM state type for the two-master AXI4 write
//   arbiter. No ports; imported by axi4_wr_arbiter and its testbench.
// -----------------------------------------------------------------------------
package axi_parameters;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 9;

  // One write transaction moves through the phases in this order.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi4_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// axi4_rr_pick
//   Two-way round-robin picker.
//   request[1:0] : pending requests, bit N = master N
//   last[0]      : 1 when master 1 was granted most recently, 0 for master 0
//   grant[1:0]   : one-hot winner, 00 when nothing is requested
// -----------------------------------------------------------------------------
module axi4_rr_pick (
  input  logic [1:0] request,
  input  logic [0:0] last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention goes to whichever master did not win last time.
      2'b11:   grant = last[0] ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_wr_arbiter
//   Arbitrates two AXI4 write masters (m0_*, m1_*) onto one slave write port
//   (s_*). One transaction is in flight at a time: the winner owns AW, then W,
//   then B, and the port is released after the B handshake.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     mN_aw* / mN_awready : master N write-address channel
//     mN_w*  / mN_wready  : master N write-data channel
//     mN_b*  / mN_bready  : master N write-response channel
//     s_aw*, s_w*, s_b*   : downstream slave write port
//     grant             : one-hot owner of the slave port (00 = none)
//     len_err           : one-cycle pulse, beat count disagreed with WLAST
// -----------------------------------------------------------------------------
module axi4_wr_arbiter
  import axi_parameters::*;
#(
  parameter int ADDR_WIDTH = axi_parameters::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_parameters::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0
  input  logic [ID_WIDTH-1:0]     m0_awid,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic [3:0]              m0_awlen,
  input  logic [2:0]              m0_awsize,
  input  logic [1:0]              m0_awburst,
  input  logic                    m0_awvalid,
  output logic                    m0_awready,
  input  logic [ID_WIDTH-1:0]     m0_wid,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m0_wlast,
  input  logic                    m0_wvalid,
  output logic                    m0_wready,
  output logic [ID_WIDTH-1:0]     m0_bid,
  output logic [1:0]              m0_bresp,
  output logic                    m0_bvalid,
  input  logic                    m0_bready,
  // master 1
  input  logic [ID_WIDTH-1:0]     m1_awid,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic [3:0]              m1_awlen,
  input  logic [2:0]              m1_awsize,
  input  logic [1:0]              m1_awburst,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [ID_WIDTH-1:0]     m1_wid,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_wlast,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [ID_WIDTH-1:0]     m1_bid,
  output logic [1:0]              m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  // slave port
  output logic [ID_WIDTH-1:0]     s_awid,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic [3:0]              s_awlen,
  output logic [2:0]              s_awsize,
  output logic [1:0]              s_awburst,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [ID_WIDTH-1:0]     s_wid,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_wlast,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [ID_WIDTH-1:0]     s_bid,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  // status
  output logic [1:0]              grant,
  output logic                    len_err
);

  wr_state_e   state_q;
  logic [1:0]  grant_q;
  logic [0:0]  last_q;      // 1 = master 1 was granted most recently
  logic [3:0]  cnt_q;       // beats remaining after the current one
  logic        len_err_q;

  logic [1:0]  pick;
  logic        sel1;
  logic        aw_v, w_v;

  axi4_rr_pick u_pick (
    .request ({m1_awvalid, m0_awvalid}),
    .last    (last_q),
    .grant   (pick)
  );

  assign sel1    = grant_q[1];
  assign grant   = grant_q;
  assign len_err = len_err_q;

  // Address channel: forward the owner's AW only while in ADDR.
  always_comb begin
    aw_v      = sel1 ? m1_awvalid : m0_awvalid;
    s_awvalid = 1'b0;
    s_awid    = '0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    if (state_q == ADDR && aw_v) begin
      s_awvalid = 1'b1;
      s_awid    = sel1 ? m1_awid    : m0_awid;
      s_awaddr  = sel1 ? m1_awaddr  : m0_awaddr;
      s_awlen   = sel1 ? m1_awlen   : m0_awlen;
      s_awsize  = sel1 ? m1_awsize  : m0_awsize;
      s_awburst = sel1 ? m1_awburst : m0_awburst;
    end
    m0_awready = (state_q == ADDR) && grant_q[0] && s_awready;
    m1_awready = (state_q == ADDR) && grant_q[1] && s_awready;
  end

  // Data channel: forward the owner's W only while in DATA.
  always_comb begin
    w_v      = sel1 ? m1_wvalid : m0_wvalid;
    s_wvalid = 1'b0;
    s_wid    = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    s_wlast  = 1'b0;
    if (state_q == DATA && w_v) begin
      s_wvalid = 1'b1;
      s_wid    = sel1 ? m1_wid   : m0_wid;
      s_wdata  = sel1 ? m1_wdata : m0_wdata;
      s_wstrb  = sel1 ? m1_wstrb : m0_wstrb;
      s_wlast  = sel1 ? m1_wlast : m0_wlast;
    end
    m0_wready = (state_q == DATA) && grant_q[0] && s_wready;
    m1_wready = (state_q == DATA) && grant_q[1] && s_wready;
  end

  // Response channel: route B back to the owner only while in RESP.
  always_comb begin
    m0_bvalid = (state_q == RESP) && grant_q[0] && s_bvalid;
    m1_bvalid = (state_q == RESP) && grant_q[1] && s_bvalid;
    m0_bid    = m0_bvalid ? s_bid   : '0;
    m0_bresp  = m0_bvalid ? s_bresp : '0;
    m1_bid    = m1_bvalid ? s_bid   : '0;
    m1_bresp  = m1_bvalid ? s_bresp : '0;
    s_bready  = (state_q == RESP) && (grant_q != 2'b00) &&
                (sel1 ? m1_bready : m0_bready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick != 2'b00) begin
            grant_q <= pick;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s_awvalid && s_awready) begin
            cnt_q   <= s_awlen;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (s_wvalid && s_wready) begin
            if (s_wlast) begin
              len_err_q <= (cnt_q != 4'd0);
              state_q   <= RESP;
            end else begin
              len_err_q <= (cnt_q == 4'd0);
            end
            // Hold at zero on an over-long burst rather than wrapping.
            if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (s_bvalid && s_bready) begin
            last_q  <= grant_q[1];
            grant_q <= 2'b00;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_wr_arbiter
//   Self-checking bench for axi4_wr_arbiter: directed scenarios followed by
//   randomized request mixes, checked against a transaction-level model of
//   the round-robin owner and of what each channel must carry.
// -----------------------------------------------------------------------------
module tb_axi4_wr_arbiter;
  localparam int AW = axi_parameters::ADDR_WIDTH;
  localparam int DW = axi_parameters::DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = axi_parameters::ID_WIDTH;

  logic clk, rst;

  logic [IW-1:0] m_awid    [2];
  logic [AW-1:0] m_awaddr  [2];
  logic [3:0]    m_awlen   [2];
  logic [2:0]    m_awsize  [2];
  logic [1:0]    m_awburst [2];
  logic          m_awvalid [2];
  logic          m_awready [2];
  logic [IW-1:0] m_wid     [2];
  logic [DW-1:0] m_wdata   [2];
  logic [SW-1:0] m_wstrb   [2];
  logic          m_wlast   [2];
  logic          m_wvalid  [2];
  logic          m_wready  [2];
  logic [IW-1:0] m_bid     [2];
  logic [1:0]    m_bresp   [2];
  logic          m_bvalid  [2];
  logic          m_bready  [2];

  logic [IW-1:0] s_awid;
  logic [AW-1:0] s_awaddr;
  logic [3:0]    s_awlen;
  logic [2:0]    s_awsize;
  logic [1:0]    s_awburst;
  logic          s_awvalid, s_awready;
  logic [IW-1:0] s_wid;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast, s_wvalid, s_wready;
  logic [IW-1:0] s_bid;
  logic [1:0]    s_bresp;
  logic          s_bvalid, s_bready;
  logic [1:0]    grant;
  logic          len_err;

  axi4_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_awid(m_awid[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]),
    .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wid(m_wid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_wlast(m_wlast[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bid(m_bid[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]),
    .m0_bready(m_bready[0]),
    .m1_awid(m_awid[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]),
    .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wid(m_wid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_wlast(m_wlast[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bid(m_bid[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]),
    .m1_bready(m_bready[1]),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the master granted most recently (reset favours m0,
  // i.e. behaves as if m1 won last) plus the request each master presented.
  int            ptr;
  logic [IW-1:0] req_id   [2];
  logic [AW-1:0] req_addr [2];
  logic [3:0]    req_len  [2];
  logic [2:0]    req_size [2];
  logic [1:0]    req_burst[2];

  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    return (ptr == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int m, input logic [AW-1:0] addr, input logic [3:0] len);
    req_id[m]    = IW'($urandom);
    req_addr[m]  = addr;
    req_len[m]   = len;
    req_size[m]  = 3'($urandom);
    req_burst[m] = 2'($urandom);
    m_awid[m]    = req_id[m];
    m_awaddr[m]  = addr;
    m_awlen[m]   = len;
    m_awsize[m]  = req_size[m];
    m_awburst[m] = req_burst[m];
    m_awvalid[m] = 1'b1;
  endtask

  // Entered one cycle after the request was seen in IDLE.
  task automatic aw_phase(input int w, input int stall);
    chk("grant_owner", 64'(grant), 64'(2'b01 << w));
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) cyc();
      chk("s_awvalid", 64'(s_awvalid), 64'd1);
      chk("s_awaddr", 64'(s_awaddr), 64'(req_addr[w]));
      chk("s_awid", 64'(s_awid), 64'(req_id[w]));
      chk("s_awlen", 64'(s_awlen), 64'(req_len[w]));
      chk("s_awsize_burst", 64'({s_awsize, s_awburst}), 64'({req_size[w], req_burst[w]}));
      chk("awready_stalled", 64'(m_awready[w]), 64'd0);
    end
    s_awready = 1'b1;
    #1;
    chk("awready_owner", 64'(m_awready[w]), 64'd1);
    chk("awready_other", 64'(m_awready[1-w]), 64'd0);
    cyc();
    s_awready    = 1'b0;
    m_awvalid[w] = 1'b0;
    #1;
    chk("s_awvalid_after", 64'(s_awvalid), 64'd0);
    chk("s_awaddr_zero", 64'(s_awaddr), 64'd0);
  endtask

  task automatic w_beat(input int w, input bit last, input bit stall,
                        input bit chk_err, input bit exp_err);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    d = DW'($urandom);
    s = SW'($urandom);
    m_wid[w]    = req_id[w];
    m_wdata[w]  = d;
    m_wstrb[w]  = s;
    m_wlast[w]  = last;
    m_wvalid[w] = 1'b1;
    s_wready    = !stall;
    #1;
    if (stall) begin
      chk("wready_stalled", 64'(m_wready[w]), 64'd0);
      cyc();
      s_wready = 1'b1;
      #1;
    end
    chk("s_wvalid", 64'(s_wvalid), 64'd1);
    chk("s_wdata", 64'(s_wdata), 64'(d));
    chk("s_wstrb_last", 64'({s_wstrb, s_wlast}), 64'({s, last}));
    chk("s_wid", 64'(s_wid), 64'(req_id[w]));
    chk("wready_owner", 64'(m_wready[w]), 64'd1);
    chk("wready_other", 64'(m_wready[1-w]), 64'd0);
    chk("awready_other_busy", 64'(m_awready[1-w]), 64'd0);
    cyc();
    m_wvalid[w] = 1'b0;
    m_wlast[w]  = 1'b0;
    s_wready    = 1'b0;
    if (chk_err) chk("len_err", 64'(len_err), 64'(exp_err));
  endtask

  task automatic b_phase(input int w, input bit bstall, input logic [1:0] resp);
    s_bvalid     = 1'b1;
    s_bid        = req_id[w];
    s_bresp      = resp;
    m_bready[w]  = !bstall;
    m_bready[1-w] = 1'b1;
    #1;
    chk("bvalid_owner", 64'(m_bvalid[w]), 64'd1);
    chk("bid_owner", 64'(m_bid[w]), 64'(req_id[w]));
    chk("bresp_owner", 64'(m_bresp[w]), 64'(resp));
    chk("b_other_zero", 64'({m_bvalid[1-w], m_bid[1-w], m_bresp[1-w]}), 64'd0);
    chk("s_bready", 64'(s_bready), 64'(!bstall));
    if (bstall) begin
      cyc();
      m_bready[w] = 1'b1;
      #1;
      chk("s_bready_late", 64'(s_bready), 64'd1);
    end
    cyc();
    s_bvalid = 1'b0;
    s_bid    = '0;
    s_bresp  = '0;
    m_bready[0] = 1'b0;
    m_bready[1] = 1'b0;
    ptr = w;
    #1;
    chk("grant_released", 64'(grant), 64'd0);
    chk("idle_s_awvalid", 64'(s_awvalid), 64'd0);
  endtask

  task automatic serve(input int w);
    aw_phase(w, int'($urandom_range(0, 2)));
    for (int i = 0; i <= int'(req_len[w]); i++)
      w_beat(w, (i == int'(req_len[w])), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    b_phase(w, 1'($urandom_range(0, 1)), 2'($urandom));
  endtask

  initial begin
    int w, r;
    rst = 1'b1;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bresp = '0;
    for (int m = 0; m < 2; m++) begin
      m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0;
      m_awburst[m] = '0; m_awvalid[m] = 0; m_wid[m] = '0; m_wdata[m] = '0;
      m_wstrb[m] = '0; m_wlast[m] = 0; m_wvalid[m] = 0; m_bready[m] = 0;
    end
    ptr = 1;
    cyc(); cyc();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_valids", 64'({s_awvalid, s_wvalid, s_bready, len_err}), 64'd0);
    chk("rst_readys", 64'({m_awready[0], m_awready[1], m_wready[0], m_wready[1]}), 64'd0);
    rst = 1'b0;
    cyc(); cyc();
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_valids", 64'({s_awvalid, s_wvalid, m_bvalid[0], m_bvalid[1]}), 64'd0);

    // Single master 0 burst of four beats, OKAY response.
    present(0, 32'h100, 4'd3);
    cyc();
    aw_phase(0, 0);
    for (int i = 0; i < 4; i++) w_beat(0, (i == 3), 1'b0, 1'b1, 1'b0);
    b_phase(0, 1'b0, 2'b00);

    // Simultaneous requests from a fresh reset pointer.
    rst = 1'b1; cyc(); rst = 1'b0; ptr = 1; cyc();
    present(0, 32'h2000, 4'd1);
    present(1, 32'h3000, 4'd2);
    w = model_pick(1'b1, 1'b1);
    cyc(); serve(w);
    cyc(); serve(1 - w);
    present(0, 32'h4000, 4'd0);
    present(1, 32'h5000, 4'd1);
    w = model_pick(1'b1, 1'b1);
    cyc(); serve(w);
    cyc(); serve(1 - w);
    // After a lone m0 transaction the tie must go to m1.
    present(0, 32'h6000, 4'd0);
    cyc(); serve(0);
    present(0, 32'h7000, 4'd0);
    present(1, 32'h8000, 4'd0);
    w = model_pick(1'b1, 1'b1);
    chk("model_tie_m1", 64'(w), 64'd1);
    cyc(); serve(w);
    cyc(); serve(1 - w);

    // Master 1 requests while master 0 is moving data.
    present(0, 32'h9000, 4'd3);
    cyc();
    aw_phase(0, 0);
    w_beat(0, 1'b0, 1'b0, 1'b1, 1'b0);
    present(1, 32'hA000, 4'd1);
    for (int i = 1; i < 4; i++) w_beat(0, (i == 3), 1'b0, 1'b1, 1'b0);
    b_phase(0, 1'b0, 2'b10);
    cyc();
    serve(1);

    // WLAST one beat early: error pulse, then RESP.
    present(0, 32'hB000, 4'd1);
    cyc();
    aw_phase(0, 0);
    w_beat(0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("len_err_one_cycle", 64'(len_err), 64'd0);
    b_phase(0, 1'b0, 2'b00);
    // WLAST missing on a single-beat burst: error pulse, still in DATA.
    present(0, 32'hC000, 4'd0);
    cyc();
    aw_phase(0, 0);
    w_beat(0, 1'b0, 1'b0, 1'b1, 1'b1);
    w_beat(0, 1'b1, 1'b0, 1'b0, 1'b0);
    b_phase(0, 1'b0, 2'b00);

    // Slave holds AWREADY low for five cycles.
    present(1, 32'hD000, 4'd2);
    cyc();
    aw_phase(1, 5);
    for (int i = 0; i < 3; i++) w_beat(1, (i == 2), 1'b0, 1'b1, 1'b0);
    b_phase(1, 1'b0, 2'b01);

    // Reset in the middle of an eight-beat burst.
    present(0, 32'hE000, 4'd7);
    cyc();
    aw_phase(0, 0);
    w_beat(0, 1'b0, 1'b0, 1'b1, 1'b0);
    w_beat(0, 1'b0, 1'b0, 1'b1, 1'b0);
    m_wvalid[0] = 1'b1; m_wdata[0] = 32'hDEAD_BEEF; s_wready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ptr = 1;
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_valids", 64'({s_awvalid, s_wvalid, s_bready, m_bvalid[0], len_err}), 64'd0);
    chk("midrst_readys", 64'({m_awready[0], m_wready[0], m_awready[1], m_wready[1]}), 64'd0);
    chk("midrst_wdata_zero", 64'(s_wdata), 64'd0);
    m_wvalid[0] = 1'b0; s_wready = 1'b0;
    present(1, 32'hF000, 4'd2);
    cyc();
    serve(1);

    // Randomized request mixes.
    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(1, 3));
      if (r[0]) present(0, AW'($urandom), 4'($urandom_range(0, 5)));
      if (r[1]) present(1, AW'($urandom), 4'($urandom_range(0, 5)));
      w = model_pick(r[0], r[1]);
      cyc();
      serve(w);
      if (r == 3) begin
        cyc();
        serve(1 - w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
